// File: rtl/dir_packer32.sv
// Packs a stream of 4-bit direction codes, 8 per 32-bit word, and writes each word to the path table.
// Latency: word buffered on its completing nibble; request issued next cycle if memory idle; done 1 cycle after final ack.
// Backpressure: in_ready drops when a word-completing nibble would find the 1-entry word buffer still occupied.
module dir_packer32 #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_2000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cell_count,
    input  logic             in_valid,
    input  logic [3:0]       in_dir,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             txn_req,
    output logic             txn_wr,
    output logic [31:0]      txn_addr,
    output logic [31:0]      txn_wdata,
    input  logic             txn_rdy
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_HOLD,
        W_WAIT
    } wstate_t;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_inc;
    logic [CNT_W-1:0] widx_q;
    logic [CNT_W-1:0] buf_widx;
    logic [2:0]       nib_q;
    logic [31:0]      pack_q;
    logic [31:0]      pack_nxt;
    logic [31:0]      buf_data;
    logic             buf_vld;
    logic             buf_last;
    wstate_t          wst;

    logic all_acc;
    logic last_nib;
    logic word_end;
    logic buf_free;
    logic take;

    assign acc_inc  = acc_q + CNT_W'(1);
    assign all_acc  = (acc_q == cnt_q);
    assign last_nib = (acc_inc == cnt_q);
    // A word closes on its 8th nibble or on the last nibble of the frame.
    assign word_end = (nib_q == 3'd7) || last_nib;
    // The buffer is released on the edge where the pending write is acknowledged.
    assign buf_free = (wst == W_WAIT) && txn_rdy;
    assign in_ready = busy && !all_acc && !(word_end && buf_vld && !buf_free);
    assign take     = in_valid && in_ready;
    assign pack_nxt = pack_q | ({28'd0, in_dir} << {nib_q, 2'b00});

    // Frame control and nibble packing: latch the frame on start, pack accepted nibbles, end the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            widx_q <= '0;
            nib_q  <= 3'd0;
            pack_q <= 32'd0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy   <= 1'b1;
                    cnt_q  <= cell_count;
                    acc_q  <= '0;
                    widx_q <= '0;
                    nib_q  <= 3'd0;
                    pack_q <= 32'd0;
                end
            end else begin
                // An empty frame has nothing to write, so it finishes one cycle after it starts.
                if ((cnt_q == '0) || (buf_free && buf_last)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                if (take) begin
                    acc_q <= acc_inc;
                    if (word_end) begin
                        nib_q  <= 3'd0;
                        pack_q <= 32'd0;
                        widx_q <= widx_q + CNT_W'(1);
                    end else begin
                        nib_q  <= nib_q + 3'd1;
                        pack_q <= pack_nxt;
                    end
                end
            end
        end
    end

    // One-entry word buffer: loaded by a completing nibble, emptied by the write acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld  <= 1'b0;
            buf_last <= 1'b0;
            buf_data <= 32'd0;
            buf_widx <= '0;
        end else if (take && word_end) begin
            buf_vld  <= 1'b1;
            buf_last <= last_nib;
            buf_data <= pack_nxt;
            buf_widx <= widx_q;
        end else if (buf_free) begin
            buf_vld  <= 1'b0;
        end
    end

    // Write sequencer: one request pulse per buffered word, then hold until memory acknowledges.
    always_ff @(posedge clk) begin
        if (rst) begin
            wst       <= W_IDLE;
            txn_req   <= 1'b0;
            txn_wr    <= 1'b0;
            txn_addr  <= 32'd0;
            txn_wdata <= 32'd0;
        end else begin
            txn_req <= 1'b0;
            txn_wr  <= 1'b0;
            case (wst)
                W_IDLE: begin
                    if (buf_vld && txn_rdy) begin
                        wst       <= W_REQ;
                        txn_req   <= 1'b1;
                        txn_wr    <= 1'b1;
                        txn_addr  <= BASE_ADDR + (32'(buf_widx) << 2);
                        txn_wdata <= buf_data;
                    end
                end
                // Memory drops txn_rdy during the cycle after the request, so it is not looked at here.
                W_REQ:  wst <= W_HOLD;
                W_HOLD: wst <= W_WAIT;
                W_WAIT: begin
                    if (txn_rdy) wst <= W_IDLE;
                end
                default: wst <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dir_packer32.sv
// Directed bench for dir_packer32 with a simple memory responder and write monitor.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Memory answers each request after a programmable number of busy cycles.
module tb_dir_packer32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cell_count;
    logic        in_valid;
    logic [3:0]  in_dir;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        txn_req;
    logic        txn_wr;
    logic [31:0] txn_addr;
    logic [31:0] txn_wdata;
    logic        txn_rdy;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dir_packer32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cell_count(cell_count),
        .in_valid  (in_valid),
        .in_dir    (in_dir),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .txn_req   (txn_req),
        .txn_wr    (txn_wr),
        .txn_addr  (txn_addr),
        .txn_wdata (txn_wdata),
        .txn_rdy   (txn_rdy)
    );

    // memory responder: goes busy after a request, idle again after mem_lat extra cycles
    int   mem_lat   = 0;
    bit   mem_block = 1'b0;
    logic rdy_r;
    int   ack_cnt;
    assign txn_rdy = rdy_r & ~mem_block;

    always @(posedge clk) begin
        if (rst) begin
            rdy_r   <= 1'b1;
            ack_cnt <= 0;
        end else if (txn_req) begin
            rdy_r   <= 1'b0;
            ack_cnt <= mem_lat;
        end else if (ack_cnt > 0) begin
            ack_cnt <= ack_cnt - 1;
        end else begin
            rdy_r   <= 1'b1;
        end
    end

    // write monitor
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int req_cnt  = 0;
    int adj_cnt  = 0;
    int wr_bad   = 0;
    int done_cnt = 0;
    bit prev_req = 1'b0;

    always @(negedge clk) begin
        if (txn_req === 1'b1) begin
            wq_addr.push_back(txn_addr);
            wq_data.push_back(txn_wdata);
            req_cnt++;
            if (prev_req) adj_cnt++;
            if (txn_wr !== 1'b1) wr_bad++;
        end else if (txn_wr === 1'b1) begin
            wr_bad++;
        end
        prev_req = (txn_req === 1'b1);
        if (done === 1'b1) done_cnt++;
    end

    logic [3:0] feed_dirs [0:31];

    task automatic start_frame(input logic [15:0] n);
        @(negedge clk);
        start      = 1'b1;
        cell_count = n;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic feed(input int n, input int budget, output int stall_at, output bit ok);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        stall_at = -1;
        while (i < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b1;
            in_dir   = feed_dirs[i];
            #1;
            if (in_ready) i++;
            else if (stall_at < 0) stall_at = i;
        end
        @(negedge clk);
        in_valid = 1'b0;
        ok = (i == n);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; cell_count = 16'd5; in_valid = 1'b1; in_dir = 4'h3;
        repeat (2) @(negedge clk);
        vecs++;
        if ({busy, done, txn_req, txn_wr, in_ready} !== 5'b0) begin
            errs++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, txn_req, txn_wr, in_ready});
        end
        vecs++;
        if (txn_addr !== 32'd0) begin errs++; $display("FAIL reset_addr: got %h want 0", txn_addr); end
        vecs++;
        if (txn_wdata !== 32'd0) begin errs++; $display("FAIL reset_wdata: got %h want 0", txn_wdata); end
        start = 1'b0; in_valid = 1'b0; in_dir = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_word();
        int stall; bit ok; int k;
        mem_lat = 0;
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < 8; i++) feed_dirs[i] = 4'(i + 1);
        start_frame(16'd8);
        vecs++;
        if (busy !== 1'b1) begin errs++; $display("FAIL t1_busy: got %b want 1", busy); end
        feed(8, 50, stall, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL t1_feed: accepted all=%0d want 1", ok); end
        k = 0;
        do begin @(negedge clk); k++; end while (txn_req !== 1'b1 && k < 50);
        vecs++;
        if (txn_req !== 1'b1) begin errs++; $display("FAIL t1_req: got %b want 1", txn_req); end
        k = 0;
        do begin @(negedge clk); k++; end while (done !== 1'b1 && k < 50);
        vecs++;
        if (k != 3) begin errs++; $display("FAIL t1_done_lat: got %0d cycles after req want 3", k); end
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL t1_busy_at_done: got %b want 0", busy); end
        @(negedge clk);
        vecs++;
        if (done !== 1'b0) begin errs++; $display("FAIL t1_done_pulse: got %b want 0", done); end
        vecs++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 32'h4000_2000 || wq_data[0] !== 32'h8765_4321) begin
            errs++;
            $display("FAIL t1_write: n=%0d addr=%h data=%h want 1 @40002000 87654321",
                     wq_addr.size(), wq_addr.size() > 0 ? wq_addr[0] : 32'hx, wq_data.size() > 0 ? wq_data[0] : 32'hx);
        end
    endtask

    task automatic test_partial_word();
        int stall; bit ok; int req0;
        mem_lat = 3;
        wq_addr.delete(); wq_data.delete();
        req0 = req_cnt;
        for (int i = 0; i < 11; i++) feed_dirs[i] = 4'hA;
        start_frame(16'd11);
        feed(11, 100, stall, ok);
        wait_done(200, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL t2_done: seen=%0d want 1", ok); end
        repeat (3) @(negedge clk);
        vecs++;
        if (req_cnt - req0 != 2) begin errs++; $display("FAIL t2_req_count: got %0d want 2", req_cnt - req0); end
        vecs++;
        if (wq_addr.size() < 2 || wq_addr[0] !== 32'h4000_2000 || wq_data[0] !== 32'hAAAA_AAAA) begin
            errs++; $display("FAIL t2_word0: n=%0d want AAAAAAAA @40002000", wq_addr.size());
        end
        vecs++;
        if (wq_addr.size() < 2 || wq_addr[1] !== 32'h4000_2004 || wq_data[1] !== 32'h0000_0AAA) begin
            errs++; $display("FAIL t2_word1: n=%0d want 00000AAA @40002004", wq_addr.size());
        end
        vecs++;
        if (adj_cnt != 0 || wr_bad != 0) begin
            errs++; $display("FAIL t2_req_shape: adjacent=%0d wr_mismatch=%0d want 0 0", adj_cnt, wr_bad);
        end
    endtask

    task automatic test_back_to_back();
        int stall; bit ok;
        mem_lat = 8;
        wq_addr.delete(); wq_data.delete();
        for (int i = 0; i < 24; i++) feed_dirs[i] = 4'((i * 3 + i / 8) % 16);
        start_frame(16'd24);
        feed(24, 400, stall, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL t3_feed: accepted all=%0d want 1", ok); end
        vecs++;
        if (stall != 15) begin errs++; $display("FAIL t3_first_stall: got nibble %0d want 15", stall); end
        wait_done(300, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL t3_done: seen=%0d want 1", ok); end
        repeat (2) @(negedge clk);
        vecs++;
        if (wq_addr.size() != 3) begin
            errs++; $display("FAIL t3_count: got %0d writes want 3", wq_addr.size());
        end else begin
            vecs++;
            if (wq_addr[0] !== 32'h4000_2000 || wq_data[0] !== 32'h52FC_9630) begin
                errs++; $display("FAIL t3_w0: got %h @%h want 52fc9630 @40002000", wq_data[0], wq_addr[0]);
            end
            vecs++;
            if (wq_addr[1] !== 32'h4000_2004 || wq_data[1] !== 32'hEB85_2FC9) begin
                errs++; $display("FAIL t3_w1: got %h @%h want eb852fc9 @40002004", wq_data[1], wq_addr[1]);
            end
            vecs++;
            if (wq_addr[2] !== 32'h4000_2008 || wq_data[2] !== 32'h741E_B852) begin
                errs++; $display("FAIL t3_w2: got %h @%h want 741eb852 @40002008", wq_data[2], wq_addr[2]);
            end
        end
    endtask

    task automatic test_empty_frame();
        int req0;
        req0 = req_cnt;
        start_frame(16'd0);
        vecs++;
        if ({busy, done, in_ready} !== 3'b100) begin
            errs++; $display("FAIL t4_first: busy/done/in_ready got %b want 100", {busy, done, in_ready});
        end
        @(negedge clk);
        vecs++;
        if ({busy, done} !== 2'b01) begin
            errs++; $display("FAIL t4_done: busy/done got %b want 01", {busy, done});
        end
        @(negedge clk);
        vecs++;
        if ({busy, done} !== 2'b00) begin
            errs++; $display("FAIL t4_after: busy/done got %b want 00", {busy, done});
        end
        vecs++;
        if (req_cnt != req0) begin errs++; $display("FAIL t4_no_write: got %0d reqs want 0", req_cnt - req0); end
    endtask

    task automatic test_stall_and_restart();
        int stall; bit ok; int nreq; int k; int unstable; int req0;
        logic [31:0] a;
        logic [31:0] d;
        mem_lat = 2;
        mem_block = 1'b1;
        wq_addr.delete(); wq_data.delete();
        req0 = req_cnt;
        feed_dirs[0] = 4'h3; feed_dirs[1] = 4'h1; feed_dirs[2] = 4'h4; feed_dirs[3] = 4'h1;
        feed_dirs[4] = 4'h5; feed_dirs[5] = 4'h9; feed_dirs[6] = 4'h2; feed_dirs[7] = 4'h6;
        start_frame(16'd8);
        feed(8, 50, stall, ok);
        nreq = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (txn_req !== 1'b0) nreq++;
            if (c == 5) begin start = 1'b1; cell_count = 16'd3; end
            else start = 1'b0;
        end
        cell_count = 16'd8;
        vecs++;
        if (nreq != 0) begin errs++; $display("FAIL t5_held_req: got %0d reqs want 0", nreq); end
        vecs++;
        if (busy !== 1'b1) begin errs++; $display("FAIL t5_busy_held: got %b want 1", busy); end
        mem_block = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (txn_req !== 1'b1 && k < 20);
        a = txn_addr;
        d = txn_wdata;
        vecs++;
        if (txn_req !== 1'b1 || a !== 32'h4000_2000 || d !== 32'h6295_1413) begin
            errs++; $display("FAIL t5_write: req=%b got %h @%h want 62951413 @40002000", txn_req, d, a);
        end
        unstable = 0;
        k = 0;
        do begin
            @(negedge clk); k++;
            if (done !== 1'b1 && (txn_addr !== a || txn_wdata !== d)) unstable++;
        end while (done !== 1'b1 && k < 50);
        vecs++;
        if (done !== 1'b1 || unstable != 0) begin
            errs++; $display("FAIL t5_stable: done=%b unstable_cycles=%0d want 1 0", done, unstable);
        end
        repeat (3) @(negedge clk);
        vecs++;
        if (req_cnt - req0 != 1 || busy !== 1'b0) begin
            errs++; $display("FAIL t5_single: reqs=%0d busy=%b want 1 0", req_cnt - req0, busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        int seen; int cyc; int i; bit hit; int req0; int done0; int stall; bit ok;
        mem_lat = 6;
        for (int j = 0; j < 24; j++) feed_dirs[j] = 4'(j);
        start_frame(16'd24);
        seen = 0; cyc = 0; i = 0; hit = 1'b0;
        while (!hit && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (txn_req === 1'b1) begin
                seen++;
                if (seen == 2) hit = 1'b1;
            end
            if (!hit && i < 24) begin
                in_valid = 1'b1; in_dir = feed_dirs[i];
                #1;
                if (in_ready) i++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        vecs++;
        if (!hit) begin errs++; $display("FAIL t6_word1_req: seen %0d reqs want 2", seen); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vecs++;
        if ({busy, done, txn_req, txn_wr, in_ready} !== 5'b0 || txn_addr !== 32'd0 || txn_wdata !== 32'd0) begin
            errs++;
            $display("FAIL t6_reset_out: ctrl=%b addr=%h data=%h want 00000 0 0",
                     {busy, done, txn_req, txn_wr, in_ready}, txn_addr, txn_wdata);
        end
        req0 = req_cnt; done0 = done_cnt;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vecs++;
        if (req_cnt != req0 || done_cnt != done0) begin
            errs++; $display("FAIL t6_aborted: reqs=%0d dones=%0d after reset want 0 0", req_cnt - req0, done_cnt - done0);
        end
        wq_addr.delete(); wq_data.delete();
        for (int j = 0; j < 8; j++) feed_dirs[j] = 4'(8 - j);
        start_frame(16'd8);
        feed(8, 50, stall, ok);
        wait_done(100, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL t6_restart_done: seen=%0d want 1", ok); end
        repeat (2) @(negedge clk);
        vecs++;
        if (wq_addr.size() != 1 || wq_addr[0] !== 32'h4000_2000 || wq_data[0] !== 32'h1234_5678) begin
            errs++;
            $display("FAIL t6_restart_write: n=%0d addr=%h data=%h want 1 @40002000 12345678",
                     wq_addr.size(), wq_addr.size() > 0 ? wq_addr[0] : 32'hx, wq_data.size() > 0 ? wq_data[0] : 32'hx);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cell_count = 16'd0; in_valid = 1'b0; in_dir = 4'h0;
        test_reset();
        test_single_word();
        test_partial_word();
        test_back_to_back();
        test_empty_frame();
        test_stall_and_restart();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
